// File: rtl/pll_reconf_ctrl.sv
// pll_reconf_ctrl: runs a full runtime PLL reconfiguration whenever the requested video mode
// changes. Selects the ROM mode, loads the altpll_reconfig scan chain, starts reconfiguration,
// waits for a stable lock and holds the video pipeline in reset for the whole sequence.
//
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   mode_req           requested mode code
//   pll_reconf_busy    busy from altpll_reconfig
//   pll_locked         PLL lock, already synchronised to clock
//   rom_mode           mode code presented to the reconfiguration ROM
//   write_from_rom     one-cycle pulse: load scan chain from ROM
//   reconfig           one-cycle pulse: apply scan chain to the PLL
//   video_reset        high while a reconfiguration is in progress
//   current_mode       mode last completed or attempted
//   busy               high whenever the sequencer is not idle
//   error              sticky timeout flag, cleared by the next successful sequence
module pll_reconf_ctrl #(
  parameter logic [7:0]  RESET_MODE         = 8'h00,
  parameter int unsigned ROM_SETUP          = 4,
  parameter int unsigned BUSY_START_TIMEOUT = 16,
  parameter int unsigned SETTLE_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT       = 1048576
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] mode_req,
  input  logic       pll_reconf_busy,
  input  logic       pll_locked,
  output logic [7:0] rom_mode,
  output logic       write_from_rom,
  output logic       reconfig,
  output logic       video_reset,
  output logic [7:0] current_mode,
  output logic       busy,
  output logic       error
);

  localparam int unsigned MaxA     = (ROM_SETUP > BUSY_START_TIMEOUT) ? ROM_SETUP
                                                                      : BUSY_START_TIMEOUT;
  localparam int unsigned MaxB     = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxParam = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW     = $clog2(MaxParam) + 1;

  // SETUP ends two counts early: the IDLE->SETUP edge already moved rom_mode and the WAIT_FREE
  // cycle registers the load pulse, so the pulse lands ROM_SETUP cycles after rom_mode changes.
  localparam logic [CntW-1:0] SetupLast  = CntW'((ROM_SETUP >= 2) ? ROM_SETUP - 2 : 0);
  localparam logic [CntW-1:0] BusyLast   = CntW'((BUSY_START_TIMEOUT >= 1) ? BUSY_START_TIMEOUT - 1
                                                                            : 0);
  localparam logic [CntW-1:0] SettleLast = CntW'((SETTLE_CYCLES >= 1) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CntW-1:0] LockLast   = CntW'((LOCK_TIMEOUT >= 1) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};

  typedef enum logic [3:0] {
    StIdle, StSetup, StWaitFree, StLoadWait, StReconf, StReconfWait, StLockWait, StDone, StAbort
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mode_q, target_q, target_d;
  logic [7:0]      rom_mode_q, rom_mode_d, current_mode_q, current_mode_d;
  logic            wfr_q, wfr_d, reconfig_q, reconfig_d;
  logic            video_reset_q, video_reset_d, busy_q, busy_d, error_q, error_d;
  logic            seen_q, seen_d;
  logic [CntW-1:0] cnt_q, cnt_d, settle_q, settle_d, cnt_inc, settle_inc;
  logic            req_valid;

  assign cnt_inc    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign settle_inc = (settle_q == CntMax) ? settle_q : settle_q + 1'b1;
  // Request must be stable for two samples and differ from the mode already applied.
  assign req_valid  = (mode_req == mode_q) && (mode_q != current_mode_q);

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    rom_mode_d     = rom_mode_q;
    current_mode_d = current_mode_q;
    wfr_d          = 1'b0;
    reconfig_d     = 1'b0;
    video_reset_d  = video_reset_q;
    busy_d         = busy_q;
    error_d        = error_q;
    seen_d         = seen_q;
    cnt_d          = cnt_q;
    settle_d       = settle_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          target_d      = mode_q;
          rom_mode_d    = mode_q;
          video_reset_d = 1'b1;
          busy_d        = 1'b1;
          cnt_d         = '0;
          state_d       = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q >= SetupLast) begin
          cnt_d   = '0;
          state_d = StWaitFree;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitFree: begin
        if (!pll_reconf_busy) begin
          wfr_d   = 1'b1;
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = StLoadWait;
        end
      end
      StLoadWait, StReconfWait: begin
        // Phase 1 waits (bounded) for busy to rise; phase 2 waits for it to fall.
        if (!seen_q) begin
          if (pll_reconf_busy) begin
            seen_d = 1'b1;
          end else if (cnt_q >= BusyLast) begin
            state_d = StAbort;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!pll_reconf_busy) begin
          seen_d   = 1'b0;
          cnt_d    = '0;
          settle_d = '0;
          state_d  = (state_q == StLoadWait) ? StReconf : StLockWait;
        end
      end
      StReconf: begin
        reconfig_d = 1'b1;
        cnt_d      = '0;
        seen_d     = 1'b0;
        state_d    = StReconfWait;
      end
      StLockWait: begin
        if (pll_locked && (settle_q >= SettleLast)) begin
          state_d = StDone;
        end else if (cnt_q >= LockLast) begin
          state_d = StAbort;
        end else begin
          settle_d = pll_locked ? settle_inc : '0;
          cnt_d    = cnt_inc;
        end
      end
      StDone: begin
        current_mode_d = target_q;
        error_d        = 1'b0;
        video_reset_d  = 1'b0;
        busy_d         = 1'b0;
        cnt_d          = '0;
        settle_d       = '0;
        state_d        = StIdle;
      end
      StAbort: begin
        current_mode_d = target_q;
        error_d        = 1'b1;
        video_reset_d  = 1'b0;
        busy_d         = 1'b0;
        cnt_d          = '0;
        settle_d       = '0;
        seen_d         = 1'b0;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      mode_q         <= RESET_MODE;
      target_q       <= RESET_MODE;
      rom_mode_q     <= RESET_MODE;
      current_mode_q <= RESET_MODE;
      wfr_q          <= 1'b0;
      reconfig_q     <= 1'b0;
      video_reset_q  <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      seen_q         <= 1'b0;
      cnt_q          <= '0;
      settle_q       <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_req;
      target_q       <= target_d;
      rom_mode_q     <= rom_mode_d;
      current_mode_q <= current_mode_d;
      wfr_q          <= wfr_d;
      reconfig_q     <= reconfig_d;
      video_reset_q  <= video_reset_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
      seen_q         <= seen_d;
      cnt_q          <= cnt_d;
      settle_q       <= settle_d;
    end
  end

  assign rom_mode       = rom_mode_q;
  assign write_from_rom = wfr_q;
  assign reconfig       = reconfig_q;
  assign video_reset    = video_reset_q;
  assign current_mode   = current_mode_q;
  assign busy           = busy_q;
  assign error          = error_q;

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// Scoreboard bench for pll_reconf_ctrl. Stimulus pushes one expected record per reconfiguration
// sequence; the monitor tracks each busy window and compares when busy falls.
// Offsets are counted in clock cycles from the first cycle busy is high.
module tb_pll_reconf_ctrl;

  logic       clock;
  logic       reset_n;
  logic [7:0] mode_req;
  logic       pll_reconf_busy;
  logic       pll_locked;
  logic [7:0] rom_mode;
  logic       write_from_rom;
  logic       reconfig;
  logic       video_reset;
  logic [7:0] current_mode;
  logic       busy;
  logic       error;

  pll_reconf_ctrl dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .mode_req        (mode_req),
    .pll_reconf_busy (pll_reconf_busy),
    .pll_locked      (pll_locked),
    .rom_mode        (rom_mode),
    .write_from_rom  (write_from_rom),
    .reconfig        (reconfig),
    .video_reset     (video_reset),
    .current_mode    (current_mode),
    .busy            (busy),
    .error           (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] target;
    int         err;
    int         wfr_off;
    int         rcf_off;  // -1: reconfig must never pulse
    int         len;      // offset of the first cycle busy is low again
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   stray    = 0;

  // Busy / lock model controls.
  bit   wfr_busy_en = 1'b1;
  int   glitch_k    = -1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req,
               $time);
    end
  endtask

  task automatic pulse_busy();
    pll_reconf_busy = 1'b1;
    repeat (20) @(negedge clock);
    pll_reconf_busy = 1'b0;
  endtask

  // altpll_reconfig + PLL model: busy for 20 cycles after each pulse; lock lost on reconfig and
  // regained 10 cycles after busy falls, optionally with a one-cycle glitch.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && write_from_rom && wfr_busy_en) begin
        pulse_busy();
      end else if (reset_n && reconfig) begin
        pll_locked = 1'b0;
        pulse_busy();
        repeat (10) @(negedge clock);
        pll_locked = 1'b1;
        if (glitch_k >= 0) begin
          repeat (glitch_k) @(negedge clock);
          pll_locked = 1'b0;
          @(negedge clock);
          pll_locked = 1'b1;
        end
      end
    end
  end

  // Monitor.
  int         in_seq = 0;
  int         off, wfr_n, rcf_n, wfr_at, rcf_at, vr_bad, both;
  logic [7:0] rom_at_rise;

  always @(negedge clock) begin : mon
    exp_t e;
    if (!reset_n) begin
      in_seq = 0;
    end else if (in_seq == 0) begin
      if (busy) begin
        in_seq      = 1;
        off         = 0;
        rom_at_rise = rom_mode;
        wfr_n       = 0;
        rcf_n       = 0;
        wfr_at      = -1;
        rcf_at      = -1;
        vr_bad      = 0;
        both        = 0;
      end else if (write_from_rom || reconfig || video_reset) begin
        stray++;
      end
    end else begin
      off++;
      if (!busy) begin
        in_seq = 0;
        check("seq_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("current_mode", int'(current_mode), int'(e.target));
          check("rom_mode", int'(rom_at_rise), int'(e.target));
          check("error", int'(error), e.err);
          check("seq_len", off, e.len);
          check("wfr_offset", wfr_at, e.wfr_off);
          check("wfr_count", wfr_n, 1);
          check("rcf_offset", rcf_at, e.rcf_off);
          check("rcf_count", rcf_n, (e.rcf_off >= 0) ? 1 : 0);
          check("video_reset_tracks_busy", vr_bad, 0);
          check("pulse_overlap", both, 0);
        end
      end
    end
    if (in_seq != 0) begin
      if (write_from_rom) begin
        wfr_n++;
        wfr_at = off;
      end
      if (reconfig) begin
        rcf_n++;
        rcf_at = off;
      end
      if (write_from_rom && reconfig) both++;
      if (video_reset != busy) vr_bad++;
    end
  end

  task automatic push(input logic [7:0] t, input int err, input int wfr, input int rcf,
                      input int len);
    exp_t e;
    e.target  = t;
    e.err     = err;
    e.wfr_off = wfr;
    e.rcf_off = rcf;
    e.len     = len;
    sb.push_back(e);
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 600; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    check(name, sb.size(), 0);
  endtask

  task automatic wait_reconfig(input string name);
    int seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (reconfig) begin
        seen = 1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    mode_req        = 8'h00;
    pll_reconf_busy = 1'b0;
    pll_locked      = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_rom_mode", int'(rom_mode), 8'h00);
    check("rst_current_mode", int'(current_mode), 8'h00);
    check("rst_busy", int'(busy), 0);
    check("rst_video_reset", int'(video_reset), 0);
    check("rst_error", int'(error), 0);
    reset_n = 1'b1;

    // Request equal to the reset mode: nothing happens.
    repeat (100) @(negedge clock);
    check("idle_busy", int'(busy), 0);
    check("idle_current_mode", int'(current_mode), 8'h00);
    check("idle_stray", stray, 0);

    // Normal sequence 00 -> 01.
    push(8'h01, 0, 4, 26, 73);
    mode_req = 8'h01;
    wait_drained("seq01_done");

    // Lock glitch after 5 locked cycles: completion 6 cycles later.
    glitch_k = 5;
    push(8'h03, 0, 4, 26, 79);
    mode_req = 8'h03;
    wait_drained("seq03_done");
    glitch_k = -1;

    // No busy after the load pulse: abort 16 cycles after the pulse, no reconfig.
    wfr_busy_en = 1'b0;
    push(8'h04, 1, 4, -1, 21);
    mode_req = 8'h04;
    wait_drained("seq04_done");
    wfr_busy_en = 1'b1;
    repeat (20) @(negedge clock);
    check("abort_no_retry", int'(busy), 0);
    check("abort_error_sticky", int'(error), 1);

    // Mode change during RECONF_WAIT: 05 completes, then 02 runs; error clears.
    push(8'h05, 0, 4, 26, 73);
    push(8'h02, 0, 4, 26, 73);
    mode_req = 8'h05;
    wait_reconfig("seq05_reconfig");
    mode_req = 8'h02;
    wait_drained("seq05_02_done");

    // Reset during LOCK_WAIT aborts asynchronously.
    mode_req = 8'h06;
    wait_reconfig("seq06_reconfig");
    repeat (25) @(negedge clock);
    check("pre_reset_busy", int'(busy), 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rom_mode", int'(rom_mode), 8'h00);
    check("async_current_mode", int'(current_mode), 8'h00);
    check("async_busy", int'(busy), 0);
    check("async_video_reset", int'(video_reset), 0);
    check("async_error", int'(error), 0);
    check("async_pulses", int'(write_from_rom) + int'(reconfig), 0);
    mode_req = 8'h00;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("post_reset_busy", int'(busy), 0);
    check("final_stray", stray, 0);
    check("final_queue", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
